// File: rtl/aurora_traffic_tester_pkg.sv
// Shared types, constants and helpers for the Aurora traffic tester.
// Optional feature macro: AURORA_TRAFFIC_ERR_INJECT_EN (used in top).
`ifndef AURORA_TT_TRUE
`define AURORA_TT_TRUE 1'b1
`define AURORA_TT_FALSE 1'b0
`endif

package aurora_traffic_tester_pkg;

  typedef enum logic [1:0] {
    ST_DOWN   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RESYNC = 2'd2
  } state_t;

  localparam int MODE_CNT  = 0;
  localparam int MODE_LFSR = 1;

  function automatic logic [63:0] default_poly(input int w);
    case (w)
      8:       return 64'h0000_0000_0000_00B8;
      32:      return 64'h0000_0000_8020_0003;
      64:      return 64'hD800_0000_0000_0000;
      default: return 64'h0000_0000_0000_B400;
    endcase
  endfunction

  function automatic int log2c(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/aurora_traffic_tester_pattern_gen.sv
// Combinational next-pattern step: counter or Galois LFSR.
// Shared by the TX generator and the RX expected-value path.
module aurora_pattern_gen
  import aurora_traffic_tester_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    MODE       = MODE_CNT,
  parameter logic [DATA_WIDTH-1:0] POLY       = '1
)(
  input  logic [DATA_WIDTH-1:0] i_x,
  output logic [DATA_WIDTH-1:0] o_next
);

  // next(x) for the selected pattern
  always_comb begin
    if (MODE == MODE_LFSR)
      o_next = (i_x >> 1) ^ (i_x[0] ? POLY : '0);
    else
      o_next = i_x + 1'b1;
  end

endmodule

// File: rtl/aurora_traffic_tester.sv
// Aurora LocalLink pattern generator/checker with lock tracking.
// Optional: define AURORA_TRAFFIC_ERR_INJECT_EN for the INJECT_ERR input.
module aurora_traffic_tester
  import aurora_traffic_tester_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    N_LANE     = 1,
  parameter int                    MODE       = MODE_CNT,
  parameter logic [DATA_WIDTH-1:0] POLY       =
    DATA_WIDTH'(default_poly(DATA_WIDTH)),
  parameter logic [DATA_WIDTH-1:0] SEED       = DATA_WIDTH'(1),
  parameter int                    CNT_WIDTH  = 32,
  parameter int                    RESYNC_N   = 4
)(
  input  logic                  USER_CLK,
  input  logic                  RESET_N,
  input  logic                  CHANNEL_UP,
  input  logic [N_LANE-1:0]     LANE_UP,
  input  logic                  HARD_ERR,
  input  logic                  SOFT_ERR,
  input  logic                  CLR_STATS,
  input  logic                  TX_DST_RDY_N,
`ifdef AURORA_TRAFFIC_ERR_INJECT_EN
  input  logic                  INJECT_ERR,
`endif
  output logic [DATA_WIDTH-1:0] TX_D,
  output logic                  TX_SRC_RDY_N,
  input  logic [DATA_WIDTH-1:0] RX_D,
  input  logic                  RX_SRC_RDY_N,
  output logic                  LOCKED,
  output logic [CNT_WIDTH-1:0]  RX_WORDS,
  output logic [CNT_WIDTH-1:0]  RX_ERRS,
  output logic [CNT_WIDTH-1:0]  SOFT_ERRS,
  output logic                  HARD_SEEN
);

  localparam int GW = log2c(RESYNC_N + 1);

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_exp, w_exp_nxt;
  logic [DATA_WIDTH-1:0] r_tx_d;
  logic [DATA_WIDTH-1:0] w_tx_adv, w_rx_adv;
  logic [GW-1:0]         r_good, w_good_nxt, w_good_inc;
  logic                  r_lock, w_lock_nxt;
  logic                  r_tx_vld;
  logic [CNT_WIDTH-1:0]  r_words, r_errs, r_soft;
  logic                  r_hard;
  logic                  w_down, w_rx_vld, w_match, w_tx_xfer;
  logic                  w_inc_word, w_inc_err;
  logic                  w_unused;

  assign w_unused   = ^LANE_UP;
  assign w_down     = !CHANNEL_UP || HARD_ERR;
  assign w_rx_vld   = !RX_SRC_RDY_N;
  assign w_match    = (RX_D == r_exp);
  assign w_tx_xfer  = r_tx_vld && !TX_DST_RDY_N;
  assign w_good_inc = r_good + 1'b1;

  aurora_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .MODE       (MODE),
    .POLY       (POLY)
  ) u_tx_gen (
    .i_x    (r_tx_d),
    .o_next (w_tx_adv)
  );

  // A matching word equals r_exp, so next(RX_D) serves both
  // the in-lock advance and the resync reseed.
  aurora_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .MODE       (MODE),
    .POLY       (POLY)
  ) u_rx_gen (
    .i_x    (RX_D),
    .o_next (w_rx_adv)
  );

  // Next state, expected word, lock and counter strobes
  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_exp;
    w_good_nxt  = r_good;
    w_lock_nxt  = r_lock;
    w_inc_word  = 1'b0;
    w_inc_err   = 1'b0;
    if (w_down) begin
      w_state_nxt = ST_DOWN;
      w_lock_nxt  = `AURORA_TT_FALSE;
    end else begin
      unique case (r_state)
        ST_DOWN: begin
          w_state_nxt = ST_RUN;
          w_exp_nxt   = SEED;
          w_good_nxt  = '0;
        end
        ST_RUN: begin
          if (w_rx_vld) begin
            w_exp_nxt = w_rx_adv;
            if (w_match) begin
              w_inc_word = 1'b1;
              w_lock_nxt = `AURORA_TT_TRUE;
            end else begin
              w_inc_err   = 1'b1;
              w_lock_nxt  = `AURORA_TT_FALSE;
              w_good_nxt  = '0;
              w_state_nxt = ST_RESYNC;
            end
          end
        end
        ST_RESYNC: begin
          if (w_rx_vld) begin
            w_exp_nxt = w_rx_adv;
            if (w_match) begin
              w_good_nxt = w_good_inc;
              if (w_good_inc == GW'(RESYNC_N)) begin
                w_good_nxt  = '0;
                w_lock_nxt  = `AURORA_TT_TRUE;
                w_state_nxt = ST_RUN;
              end
            end else begin
              w_inc_err  = 1'b1;
              w_good_nxt = '0;
            end
          end
        end
        default: w_state_nxt = ST_DOWN;
      endcase
    end
  end

  // FSM, checker and TX pattern registers
  always_ff @(posedge USER_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= ST_DOWN;
      r_exp    <= SEED;
      r_good   <= '0;
      r_lock   <= 1'b0;
      r_tx_d   <= SEED;
      r_tx_vld <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_exp    <= w_exp_nxt;
      r_good   <= w_good_nxt;
      r_lock   <= w_lock_nxt;
      r_tx_vld <= !w_down && (r_state != ST_DOWN);
      if (r_state == ST_DOWN)
        r_tx_d <= SEED;
      else if (w_tx_xfer)
        r_tx_d <= w_tx_adv;
    end
  end

  // Saturating statistics; a clear pulse wins over increments
  always_ff @(posedge USER_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_words <= '0;
      r_errs  <= '0;
      r_soft  <= '0;
      r_hard  <= 1'b0;
    end else if (CLR_STATS) begin
      r_words <= '0;
      r_errs  <= '0;
      r_soft  <= '0;
      r_hard  <= 1'b0;
    end else begin
      if (w_inc_word && !(&r_words))
        r_words <= r_words + 1'b1;
      if (w_inc_err && !(&r_errs))
        r_errs <= r_errs + 1'b1;
      if (SOFT_ERR && !(&r_soft))
        r_soft <= r_soft + 1'b1;
      if (HARD_ERR)
        r_hard <= 1'b1;
    end
  end

`ifdef AURORA_TRAFFIC_ERR_INJECT_EN
  logic r_inj;

  // Arm on a pulse; disarm once the corrupted word is taken
  always_ff @(posedge USER_CLK or negedge RESET_N) begin
    if (!RESET_N)
      r_inj <= 1'b0;
    else if (r_inj && w_tx_xfer)
      r_inj <= 1'b0;
    else if (INJECT_ERR)
      r_inj <= 1'b1;
  end

  assign TX_D = r_tx_d ^ {{(DATA_WIDTH-1){1'b0}}, r_inj};
`else
  assign TX_D = r_tx_d;
`endif

  assign TX_SRC_RDY_N = !r_tx_vld;
  assign LOCKED       = r_lock;
  assign RX_WORDS     = r_words;
  assign RX_ERRS      = r_errs;
  assign SOFT_ERRS    = r_soft;
  assign HARD_SEEN    = r_hard;

endmodule

// File: tb/tb_aurora_traffic_tester.sv
// Loopback bench: counter DUT (32-bit stats) and LFSR DUT (4-bit stats)
// driven in lockstep, checked by a queue-based scoreboard.
module tb_aurora_traffic_tester;

  localparam logic [15:0] SEED = 16'h0001;
  localparam logic [15:0] POLY = 16'hB400;
  localparam int          RSN  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, chan_up, hard_err, soft_err, clr, dst_rdy_n;
  logic [0:0]  lane_up;
  logic [15:0] tx_d0, tx_d1, rx_d0, rx_d1;
  logic        tx_src0, tx_src1, rx_vld_n0, rx_vld_n1;
  logic        locked0, locked1, hard0, hard1;
  logic [31:0] words0, errs0, soft0;
  logic [3:0]  words1, errs1, soft1;

  aurora_traffic_tester #(
    .DATA_WIDTH (16), .N_LANE (1), .MODE (0), .POLY (POLY),
    .SEED (SEED), .CNT_WIDTH (32), .RESYNC_N (RSN)
  ) u_dut0 (
    .USER_CLK (clk), .RESET_N (rst_n), .CHANNEL_UP (chan_up),
    .LANE_UP (lane_up), .HARD_ERR (hard_err), .SOFT_ERR (soft_err),
    .CLR_STATS (clr), .TX_DST_RDY_N (dst_rdy_n), .TX_D (tx_d0),
    .TX_SRC_RDY_N (tx_src0), .RX_D (rx_d0), .RX_SRC_RDY_N (rx_vld_n0),
    .LOCKED (locked0), .RX_WORDS (words0), .RX_ERRS (errs0),
    .SOFT_ERRS (soft0), .HARD_SEEN (hard0)
  );

  aurora_traffic_tester #(
    .DATA_WIDTH (16), .N_LANE (1), .MODE (1), .POLY (POLY),
    .SEED (SEED), .CNT_WIDTH (4), .RESYNC_N (RSN)
  ) u_dut1 (
    .USER_CLK (clk), .RESET_N (rst_n), .CHANNEL_UP (chan_up),
    .LANE_UP (lane_up), .HARD_ERR (hard_err), .SOFT_ERR (soft_err),
    .CLR_STATS (clr), .TX_DST_RDY_N (dst_rdy_n), .TX_D (tx_d1),
    .TX_SRC_RDY_N (tx_src1), .RX_D (rx_d1), .RX_SRC_RDY_N (rx_vld_n1),
    .LOCKED (locked1), .RX_WORDS (words1), .RX_ERRS (errs1),
    .SOFT_ERRS (soft1), .HARD_SEEN (hard1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Reference model: pattern rule, lock tracking, statistics
  function automatic logic [15:0] ref_next(input int d, input logic [15:0] x);
    if (d == 0) return x + 16'd1;
    return (x >> 1) ^ (x[0] ? POLY : 16'h0000);
  endfunction

  function automatic logic [31:0] sat(input int d, input longint v);
    if (d == 1 && v > 15) return 32'd15;
    return 32'(v);
  endfunction

  logic [15:0] m_exp[2];
  logic [15:0] m_tx[2];
  bit          m_resync[2];
  bit          m_lock[2];
  int          m_good[2];
  longint      m_words[2];
  longint      m_errs[2];
  int          m_soft;
  bit          m_hard;

  task automatic model_down();
    for (int d = 0; d < 2; d++) begin
      m_resync[d] = 0; m_lock[d] = 0; m_good[d] = 0;
      m_exp[d] = SEED; m_tx[d] = SEED;
    end
  endtask

  task automatic model_rx(input int d, input logic [15:0] w);
    if (w == m_exp[d]) begin
      if (m_resync[d]) begin
        m_good[d]++;
        if (m_good[d] == RSN) begin
          m_resync[d] = 0; m_lock[d] = 1;
        end
      end else begin
        m_words[d]++; m_lock[d] = 1;
      end
    end else begin
      m_errs[d]++; m_lock[d] = 0; m_resync[d] = 1; m_good[d] = 0;
    end
    m_exp[d] = ref_next(d, w);
  endtask

  typedef struct {
    int          d;
    int          due;
    logic [31:0] words;
    logic [31:0] errs;
    logic        lock;
  } exp_t;

  exp_t        q[$];
  bit          mon_en = 1;
  logic [15:0] cap[4];
  int          n_cap = 0;
  int          rx_cnt0 = 0;
  int          corrupt_idx = -1;

  // Monitor: scoreboard pops and TX pattern checks
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (mon_en) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        e = q.pop_front();
        if (e.d == 0) begin
          check("rx_words0", words0, e.words);
          check("rx_errs0", errs0, e.errs);
          check("locked0", locked0, e.lock);
        end else begin
          check("rx_words1", words1, e.words);
          check("rx_errs1", errs1, e.errs);
          check("locked1", locked1, e.lock);
        end
      end
      if (!tx_src0 && !dst_rdy_n) begin
        check("tx_d0", tx_d0, m_tx[0]);
        m_tx[0] = ref_next(0, m_tx[0]);
      end
      if (!tx_src1 && !dst_rdy_n) begin
        check("tx_d1", tx_d1, m_tx[1]);
        m_tx[1] = ref_next(1, m_tx[1]);
        if (n_cap < 4) begin
          cap[n_cap] = tx_d1;
          n_cap++;
        end
      end
    end
  end

  // One clock of loopback: model the coming edge, then drive RX
  task automatic cycle();
    logic        x0, x1;
    logic [15:0] w0, w1;
    @(negedge clk);
    if (!rx_vld_n0) model_rx(0, rx_d0);
    if (!rx_vld_n1) model_rx(1, rx_d1);
    if (soft_err) m_soft++;
    if (hard_err) m_hard = 1;
    if (clr) begin
      m_words = '{0, 0}; m_errs = '{0, 0}; m_soft = 0; m_hard = 0;
    end
    if (!rx_vld_n0 || clr)
      q.push_back('{0, cyc, sat(0, m_words[0]), sat(0, m_errs[0]), m_lock[0]});
    if (!rx_vld_n1 || clr)
      q.push_back('{1, cyc, sat(1, m_words[1]), sat(1, m_errs[1]), m_lock[1]});
    x0 = !tx_src0 && !dst_rdy_n;
    x1 = !tx_src1 && !dst_rdy_n;
    w0 = tx_d0;
    w1 = tx_d1;
    @(posedge clk);
    #1;
    if (x0) begin
      rx_cnt0++;
      if (rx_cnt0 == corrupt_idx) w0 = 16'hDEAD;
    end
    rx_vld_n0 = !x0; rx_d0 = x0 ? w0 : 16'($urandom);
    rx_vld_n1 = !x1; rx_d1 = x1 ? w1 : 16'($urandom);
  endtask

  task automatic run_to(input int target);
    int n;
    n = 0;
    while (rx_cnt0 < target && n < 2000) begin
      if (($urandom % 8) == 0) dst_rdy_n = 1'b1;
      else dst_rdy_n = 1'b0;
      cycle();
      n++;
    end
    n_tests++;
    if (rx_cnt0 < target) begin
      n_fail++;
      $display("FAIL run_to: got %0d words, want %0d", rx_cnt0, target);
    end
  endtask

  task automatic drain();
    dst_rdy_n = 1'b1;
    repeat (3) cycle();
  endtask

  initial begin
    rst_n = 0; chan_up = 0; hard_err = 0; soft_err = 0; clr = 0;
    dst_rdy_n = 0; lane_up = 1'b1;
    rx_vld_n0 = 1; rx_vld_n1 = 1; rx_d0 = '0; rx_d1 = '0;
    m_words = '{0, 0}; m_errs = '{0, 0}; m_soft = 0; m_hard = 0;
    model_down();
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_d0", tx_d0, SEED);
    check("rst_tx_d1", tx_d1, SEED);
    check("rst_src0", tx_src0, 1'b1);
    check("rst_locked0", locked0, 1'b0);
    check("rst_words0", words0, 0);
    check("rst_hard0", hard0, 1'b0);
    rst_n = 1;
    cycle(); cycle();
    check("down_src0", tx_src0, 1'b1);

    // clean loopback, first 100 words
    chan_up = 1;
    run_to(100);
    drain();
    check("clean_words0", words0, 100);
    check("clean_errs0", errs0, 0);
    check("clean_lock0", locked0, 1'b1);
    check("sat_words1", words1, 15);
    check("lfsr_w0", cap[0], 16'h0001);
    check("lfsr_w1", cap[1], 16'hB400);
    check("lfsr_w2", cap[2], 16'h5A00);
    check("lfsr_w3", cap[3], 16'h2D00);

    // TX stall: word held and still offered
    repeat (5) begin
      cycle();
      check("stall_tx_d0", tx_d0, m_tx[0]);
      check("stall_src0", tx_src0, 1'b0);
    end

    // corrupt one received word, watch resync
    corrupt_idx = 150;
    run_to(200);
    drain();
    check("resync_errs0", errs0, m_errs[0]);
    check("resync_words0", words0, m_words[0]);
    check("resync_lock0", locked0, 1'b1);

    // soft error pulses
    repeat (3) begin
      soft_err = 1; cycle(); soft_err = 0; cycle();
    end
    check("soft0", soft0, 3);
    check("soft1", soft1, 3);

    // channel drop and restart
    chan_up = 0;
    model_down();
    cycle();
    repeat (10) begin
      check("down_src0", tx_src0, 1'b1);
      check("down_lock0", locked0, 1'b0);
      cycle();
    end
    check("kept_words0", words0, m_words[0]);
    chan_up = 1;
    run_to(rx_cnt0 + 30);
    drain();

    // hard error
    hard_err = 1;
    model_down();
    cycle();
    hard_err = 0;
    check("hard_seen0", hard0, 1'b1);
    check("hard_seen1", hard1, 1'b1);
    check("hard_src0", tx_src0, 1'b1);
    check("hard_lock0", locked0, 1'b0);
    run_to(rx_cnt0 + 20);

    // clear while traffic flows
    dst_rdy_n = 0;
    clr = 1;
    cycle();
    clr = 0;
    check("clr_hard0", hard0, 1'b0);
    check("clr_soft0", soft0, 0);
    run_to(rx_cnt0 + 10);
    drain();
    check("clr_words0", words0, m_words[0]);
    check("clr_errs0", errs0, m_errs[0]);

    // reset in the middle of traffic
    run_to(rx_cnt0 + 5);
    mon_en = 0;
    q.delete();
    rst_n = 0;
    #1;
    check("mid_rst_tx_d0", tx_d0, SEED);
    check("mid_rst_tx_d1", tx_d1, SEED);
    check("mid_rst_src0", tx_src0, 1'b1);
    check("mid_rst_lock0", locked0, 1'b0);
    check("mid_rst_words0", words0, 0);
    check("mid_rst_errs0", errs0, 0);
    check("mid_rst_soft0", soft0, 0);
    check("mid_rst_words1", words1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
